// File: rtl/crumb_pkg.sv
// Shared defaults and helpers for the crumb chain collector.
package crumb_pkg;

    localparam int unsigned CRUMB_WORD_W     = 8;
    localparam int unsigned CRUMB_FIFO_DEPTH = 4;
    localparam int unsigned CRUMB_DROP_W     = 8;

    // Occupancy needs one extra bit so that a full FIFO (DEPTH) is representable.
    function automatic int unsigned crumb_fill_w(input int unsigned depth);
        return 32'($clog2(depth)) + 32'd1;
    endfunction

endpackage

// File: rtl/crumb_fifo.sv
// Generic synchronous first-word-fall-through FIFO with cleared storage.
module crumb_fifo
    import crumb_pkg::*;
#(
    parameter  int unsigned W      = 8,
    parameter  int unsigned DEPTH  = 4,
    localparam int unsigned FILL_W = crumb_fill_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              push,
    input  logic [W-1:0]      push_data,
    input  logic              pop,
    output logic [W-1:0]      head,
    output logic              empty,
    output logic              full,
    output logic [FILL_W-1:0] fill
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]      mem_q [DEPTH];
    logic [FILL_W-1:0] wr_q, wr_d;
    logic [FILL_W-1:0] rd_q, rd_d;
    logic              push_ok_c;
    logic              pop_ok_c;

    // A push into a full FIFO is only legal when the head leaves on the same edge.
    assign pop_ok_c  = pop && !empty;
    assign push_ok_c = push && (!full || pop_ok_c);

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (clr) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (push_ok_c) wr_d = wr_q + FILL_W'(1);
            if (pop_ok_c)  rd_d = rd_q + FILL_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else if (push_ok_c) begin
            mem_q[wr_q[AW-1:0]] <= push_data;
        end
    end

    assign head  = mem_q[rd_q[AW-1:0]];
    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign fill  = wr_q - rd_q;

endmodule

// File: rtl/crumb_collector.sv
// Packs chain random bits MSB-first into words and buffers them; words that
// find the buffer full are dropped and counted so the chain never stalls.
module crumb_collector
    import crumb_pkg::*;
#(
    parameter  int unsigned WORD_W = CRUMB_WORD_W,
    parameter  int unsigned DEPTH  = CRUMB_FIFO_DEPTH,
    parameter  int unsigned DROP_W = CRUMB_DROP_W,
    localparam int unsigned FILL_W = crumb_fill_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic              rbit_i,
    input  logic              clr_i,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FILL_W-1:0] fill,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_count
);

    localparam int unsigned BCNT_W = $clog2(WORD_W);

    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;
    logic              overflow_q, overflow_d;
    logic [DROP_W-1:0] drop_q, drop_d;

    logic [WORD_W-1:0] word_c;
    logic              word_done_c;
    logic              pop_c;
    logic              full_c;
    logic              empty_c;

    assign word_c      = {shreg_q[WORD_W-2:0], rbit_i};
    assign word_done_c = en_i && !clr_i && (bcnt_q == BCNT_W'(WORD_W - 1));
    assign pop_c       = !empty_c && out_ready;

    always_comb begin
        shreg_d    = shreg_q;
        bcnt_d     = bcnt_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;
        if (clr_i) begin
            shreg_d    = '0;
            bcnt_d     = '0;
            overflow_d = 1'b0;
            drop_d     = '0;
        end else begin
            if (en_i) begin
                shreg_d = word_c;
                bcnt_d  = word_done_c ? '0 : bcnt_q + BCNT_W'(1);
            end
            // Full with no simultaneous pop: the completed word is lost.
            if (word_done_c && full_c && !pop_c) begin
                overflow_d = 1'b1;
                if (drop_q != '1) drop_d = drop_q + DROP_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q    <= '0;
            bcnt_q     <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            shreg_q    <= shreg_d;
            bcnt_q     <= bcnt_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    crumb_fifo #(
        .W     (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr_i),
        .push      (word_done_c),
        .push_data (word_c),
        .pop       (pop_c),
        .head      (out_data),
        .empty     (empty_c),
        .full      (full_c),
        .fill      (fill)
    );

    assign out_valid  = !empty_c;
    assign overflow   = overflow_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_crumb_collector.sv
// Randomized and directed bench for crumb_collector against a queue-based model.
module tb_crumb_collector;
    import crumb_pkg::*;

    localparam int unsigned WORD_W = 8;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned DROP_W = 8;
    localparam int unsigned FILL_W = crumb_fill_w(DEPTH);

    logic              clk = 1'b0;
    logic              rst;
    logic              en_i;
    logic              rbit_i;
    logic              clr_i;
    logic              out_ready;
    logic [WORD_W-1:0] out_data;
    logic              out_valid;
    logic [FILL_W-1:0] fill;
    logic              overflow;
    logic [DROP_W-1:0] drop_count;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference model: bit accumulator, word queue, drop bookkeeping.
    int unsigned m_acc;
    int unsigned m_nb;
    int unsigned m_drops;
    bit          m_ovf;
    int unsigned m_q[$];

    crumb_collector #(
        .WORD_W (WORD_W),
        .DEPTH  (DEPTH),
        .DROP_W (DROP_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en_i       (en_i),
        .rbit_i     (rbit_i),
        .clr_i      (clr_i),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fill       (fill),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_clear();
        m_acc   = 0;
        m_nb    = 0;
        m_drops = 0;
        m_ovf   = 1'b0;
        m_q.delete();
    endfunction

    function automatic void model_edge(input bit en, input bit b, input bit rdy, input bit clr);
        bit done;
        bit pop;
        if (clr) begin
            model_clear();
            return;
        end
        done = 1'b0;
        pop  = rdy && (m_q.size() != 0);
        if (en) begin
            m_acc = (m_acc * 2 + int'(b)) % (1 << WORD_W);
            m_nb++;
            if (m_nb == WORD_W) begin
                m_nb = 0;
                done = 1'b1;
            end
        end
        if (pop) void'(m_q.pop_front());
        if (done) begin
            if (m_q.size() < DEPTH) begin
                m_q.push_back(m_acc);
            end else begin
                m_ovf = 1'b1;
                if (m_drops < (1 << DROP_W) - 1) m_drops++;
            end
        end
    endfunction

    task automatic compare_model();
        chk("valid",    32'(out_valid),  32'(m_q.size() != 0));
        chk("fill",     32'(fill),       32'(m_q.size()));
        chk("overflow", 32'(overflow),   32'(m_ovf));
        chk("drops",    32'(drop_count), m_drops);
        if (m_q.size() != 0) chk("data", 32'(out_data), m_q[0]);
    endtask

    task automatic step(input bit en, input bit b, input bit rdy, input bit clr);
        en_i      = en;
        rbit_i    = b;
        out_ready = rdy;
        clr_i     = clr;
        @(posedge clk);
        model_edge(en, b, rdy, clr);
        #1;
        compare_model();
    endtask

    task automatic send_word(input logic [7:0] w, input bit rdy, input bit last_rdy);
        for (int i = 7; i >= 0; i--) step(1'b1, w[i], (i == 0) ? last_rdy : rdy, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_clear();
        for (int i = 0; i < 3; i++) begin
            en_i   = i[0];
            rbit_i = ~i[0];
            #1;
            compare_model();
            chk("rst_data", 32'(out_data), 32'h0);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        en_i      = 1'b0;
        rbit_i    = 1'b0;
        clr_i     = 1'b0;
        out_ready = 1'b0;

        // 1. Reset
        do_reset();

        // 2. Basic word
        send_word(8'hB2, 1'b0, 1'b0);
        chk("basic_valid", 32'(out_valid), 32'h1);
        chk("basic_data",  32'(out_data),  32'hB2);
        chk("basic_fill",  32'(fill),      32'h1);

        // 3. Pause mid-word
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, i[0], 1'b0, 1'b0);
            chk("pause_valid", 32'(out_valid), 32'h0);
        end
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("pause_data", 32'(out_data), 32'hF0);

        // 4. Overflow then drain
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 5; k++) send_word(8'(k), 1'b0, 1'b0);
        chk("ovf_fill",  32'(fill),       32'h4);
        chk("ovf_flag",  32'(overflow),   32'h1);
        chk("ovf_drops", 32'(drop_count), 32'h1);
        for (int k = 1; k <= 4; k++) begin
            chk("drain_data", 32'(out_data), 32'(k));
            step(1'b0, 1'b0, 1'b1, 1'b0);
        end
        chk("drain_empty", 32'(out_valid), 32'h0);

        // 5. Full with simultaneous pop/push, then saturation
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) send_word(8'(8'h10 + k), 1'b0, 1'b0);
        send_word(8'h99, 1'b0, 1'b1);
        chk("fp_drops", 32'(drop_count), 32'h0);
        chk("fp_fill",  32'(fill),       32'h4);
        chk("fp_ovf",   32'(overflow),   32'h0);
        for (int k = 0; k < 300; k++) send_word(8'($urandom), 1'b0, 1'b0);
        chk("sat_drops", 32'(drop_count), 32'hFF);

        // 6. Reset and clear mid-word
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        do_reset();
        send_word(8'h5A, 1'b0, 1'b0);
        chk("rstmid_data", 32'(out_data), 32'h5A);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("clrmid_fill0", 32'(fill), 32'h0);
        send_word(8'h5A, 1'b0, 1'b0);
        chk("clrmid_data", 32'(out_data), 32'h5A);
        chk("clrmid_fill", 32'(fill),     32'h1);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, 1'($urandom),
                 $urandom_range(0, 2) == 0, $urandom_range(0, 299) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
